// File: rtl/hazard_step_ctrl_if.sv
// hazard_step_ctrl_if: hazard, forwarding and run-control signals between the pipeline and hazard_step_ctrl
interface hazard_step_ctrl_if #(parameter int ICNT_W = 16);
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD;
  logic run_req, halt_req, step_req;
  logic StalIF, StalID, FlushD, FlushE, ForwardAD, ForwardBD, halted;
  logic [1:0] ForwardAE, ForwardBE;
  logic [ICNT_W-1:0] issue_cnt;
  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD,
           run_req, halt_req, step_req,
    input  StalIF, StalID, FlushD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           halted, issue_cnt
  );
  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD,
           run_req, halt_req, step_req,
    output StalIF, StalID, FlushD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           halted, issue_cnt
  );
endinterface

// File: rtl/hazard_step_ctrl.sv
// hazard_step_ctrl: live hazard detection, forwarding select and run/halt/step control for the 5-stage core
module hazard_step_ctrl #(parameter int ICNT_W = 16) (
  input logic clk,
  input logic rst_n,
  hazard_step_ctrl_if.slave bus
);
  typedef enum logic [1:0] {HALTED, RUN, STEP} state_e;
  state_e state_q, state_d;
  logic [ICNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic m_rs_e, w_rs_e, m_rt_e, w_rt_e, lwstall, branchstall, stall, advance;
  logic e_hits_d, m_hits_d;
  // register 0 is hardwired, so a zero source never matches a producer
  assign m_rs_e = bus.RsE != 5'd0 && bus.RsE == bus.WriteRegM && bus.RegWriteM;
  assign w_rs_e = bus.RsE != 5'd0 && bus.RsE == bus.WriteRegW && bus.RegWriteW;
  assign m_rt_e = bus.RtE != 5'd0 && bus.RtE == bus.WriteRegM && bus.RegWriteM;
  assign w_rt_e = bus.RtE != 5'd0 && bus.RtE == bus.WriteRegW && bus.RegWriteW;
  assign bus.ForwardAE = m_rs_e ? 2'b10 : w_rs_e ? 2'b01 : 2'b00;
  assign bus.ForwardBE = m_rt_e ? 2'b10 : w_rt_e ? 2'b01 : 2'b00;
  assign bus.ForwardAD = bus.RsD != 5'd0 && bus.RsD == bus.WriteRegM && bus.RegWriteM;
  assign bus.ForwardBD = bus.RtD != 5'd0 && bus.RtD == bus.WriteRegM && bus.RegWriteM;
  assign lwstall = bus.MemtoRegE && bus.RtE != 5'd0 && (bus.RtE == bus.RsD || bus.RtE == bus.RtD);
  assign e_hits_d = bus.WriteRegE != 5'd0 && (bus.WriteRegE == bus.RsD || bus.WriteRegE == bus.RtD);
  assign m_hits_d = bus.WriteRegM != 5'd0 && (bus.WriteRegM == bus.RsD || bus.WriteRegM == bus.RtD);
  assign branchstall = bus.BranchD && ((bus.RegWriteE && e_hits_d) || (bus.MemtoRegM && m_hits_d));
  assign stall = lwstall || branchstall;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HALTED;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end
  // halt always wins; a step leaves on its first unstalled cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      HALTED:  state_d = bus.halt_req ? HALTED : bus.step_req ? STEP : bus.run_req ? RUN : HALTED;
      RUN:     state_d = bus.halt_req ? HALTED : RUN;
      STEP:    state_d = (bus.halt_req || !stall) ? HALTED : STEP;
      default: state_d = HALTED;
    endcase
  end
  always_comb begin
    advance     = (state_q == RUN || state_q == STEP) && !stall;
    issue_cnt_d = advance ? issue_cnt_q + 1'b1 : issue_cnt_q;
  end
  assign bus.StalIF    = advance;
  assign bus.StalID    = advance;
  assign bus.FlushE    = !advance;
  assign bus.FlushD    = bus.PCSrcD && advance;
  assign bus.halted    = state_q == HALTED;
  assign bus.issue_cnt = issue_cnt_q;
endmodule

// File: tb/tb_hazard_step_ctrl.sv
// tb_hazard_step_ctrl: directed vectors for hazard_step_ctrl with hand-computed expectations
module tb_hazard_step_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  hazard_step_ctrl_if #(.ICNT_W(16)) bus ();
  hazard_step_ctrl #(.ICNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_hz();
    bus.RsD = 0; bus.RtD = 0; bus.RsE = 0; bus.RtE = 0;
    bus.WriteRegE = 0; bus.WriteRegM = 0; bus.WriteRegW = 0;
    bus.RegWriteE = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
    bus.MemtoRegE = 0; bus.MemtoRegM = 0; bus.BranchD = 0; bus.PCSrcD = 0;
  endtask
  task automatic check_adv(input string tag, input logic adv);
    check({tag, "_stalif"}, 32'(bus.StalIF), 32'(adv));
    check({tag, "_stalid"}, 32'(bus.StalID), 32'(adv));
    check({tag, "_flushe"}, 32'(bus.FlushE), 32'(!adv));
  endtask
  initial begin
    clear_hz();
    bus.run_req = 0; bus.halt_req = 0; bus.step_req = 0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check_adv("reset", 1'b0);
    check("reset_halted", 32'(bus.halted), 1);
    check("reset_cnt", 32'(bus.issue_cnt), 0);
    check("reset_flushd", 32'(bus.FlushD), 0);
    check("reset_fwd", {28'd0, bus.ForwardAE, bus.ForwardBE}, 0);
    bus.run_req = 1; tick(); bus.run_req = 0;
    check_adv("run", 1'b1);
    check("run_halted", 32'(bus.halted), 0);
    check("run_cnt0", 32'(bus.issue_cnt), 0);
    for (int i = 0; i < 9; i++) tick();
    check("run_cnt9", 32'(bus.issue_cnt), 9);
    bus.halt_req = 1; tick(); bus.halt_req = 0;
    check_adv("halt", 1'b0);
    check("halt_halted", 32'(bus.halted), 1);
    check("halt_cnt", 32'(bus.issue_cnt), 10);
    tick();
    check("halt_cnt_hold", 32'(bus.issue_cnt), 10);
    bus.run_req = 1; tick(); bus.run_req = 0;
    bus.MemtoRegE = 1; bus.RegWriteE = 1; bus.RtE = 5; bus.RsD = 5;
    #1;
    check_adv("lw_rs", 1'b0);
    tick();
    check("lw_cnt_hold", 32'(bus.issue_cnt), 10);
    bus.RsD = 0; bus.RtD = 5;
    #1;
    check_adv("lw_rt", 1'b0);
    bus.RtE = 0; bus.RtD = 0;
    #1;
    check_adv("lw_rte0", 1'b1);
    clear_hz();
    bus.halt_req = 1; tick(); bus.halt_req = 0;
    check("lw_halt_cnt", 32'(bus.issue_cnt), 11);
    bus.RsE = 3; bus.WriteRegM = 3; bus.WriteRegW = 3; bus.RegWriteM = 1; bus.RegWriteW = 1;
    #1;
    check("fae_mem", 32'(bus.ForwardAE), 2);
    check("fbe_none", 32'(bus.ForwardBE), 0);
    bus.RegWriteM = 0; #1;
    check("fae_wb", 32'(bus.ForwardAE), 1);
    bus.RsE = 0; #1;
    check("fae_r0", 32'(bus.ForwardAE), 0);
    bus.RtE = 3; bus.RegWriteM = 1; #1;
    check("fbe_mem", 32'(bus.ForwardBE), 2);
    bus.RegWriteM = 0; #1;
    check("fbe_wb", 32'(bus.ForwardBE), 1);
    bus.RtE = 0; #1;
    check("fbe_r0", 32'(bus.ForwardBE), 0);
    bus.RsD = 3; bus.RegWriteM = 1; #1;
    check("fad_hit", 32'(bus.ForwardAD), 1);
    check("fbd_r0", 32'(bus.ForwardBD), 0);
    bus.WriteRegM = 0; bus.RsD = 0; #1;
    check("fad_r0", 32'(bus.ForwardAD), 0);
    clear_hz();
    bus.MemtoRegE = 1; bus.RtE = 5; bus.RsD = 5;
    bus.step_req = 1; tick(); bus.step_req = 0;
    check_adv("step_c1", 1'b0);
    check("step_c1_halted", 32'(bus.halted), 0);
    tick();
    check_adv("step_c2", 1'b0);
    check("step_c2_cnt", 32'(bus.issue_cnt), 11);
    bus.MemtoRegE = 0; #1;
    check_adv("step_go", 1'b1);
    tick();
    check_adv("step_done", 1'b0);
    check("step_done_halted", 32'(bus.halted), 1);
    check("step_done_cnt", 32'(bus.issue_cnt), 12);
    clear_hz();
    bus.run_req = 1; tick(); bus.run_req = 0;
    bus.BranchD = 1; bus.RegWriteE = 1; bus.WriteRegE = 7; bus.RsD = 7; bus.PCSrcD = 1;
    #1;
    check_adv("br_e", 1'b0);
    check("br_e_flushd", 32'(bus.FlushD), 0);
    bus.RegWriteE = 0; #1;
    check_adv("br_clear", 1'b1);
    check("br_clear_flushd", 32'(bus.FlushD), 1);
    bus.RsD = 0; bus.RtD = 7; bus.MemtoRegM = 1; bus.WriteRegM = 7; bus.PCSrcD = 0; #1;
    check_adv("br_m", 1'b0);
    clear_hz();
    bus.halt_req = 1; tick(); bus.halt_req = 0;
    check("br_halt_cnt", 32'(bus.issue_cnt), 13);
    bus.PCSrcD = 1; #1;
    check("halted_flushd", 32'(bus.FlushD), 0);
    bus.PCSrcD = 0;
    bus.halt_req = 1; bus.run_req = 1; tick();
    check("halt_run_halted", 32'(bus.halted), 1);
    bus.run_req = 0; bus.step_req = 1; tick();
    check("halt_step_halted", 32'(bus.halted), 1);
    bus.halt_req = 0; tick(); bus.step_req = 0;
    check_adv("free_step", 1'b1);
    tick();
    check("free_step_halted", 32'(bus.halted), 1);
    check("free_step_cnt", 32'(bus.issue_cnt), 14);
    bus.run_req = 1; tick(); bus.run_req = 0;
    tick();
    check("pre_rst_cnt", 32'(bus.issue_cnt), 15);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("midrun_rst_halted", 32'(bus.halted), 1);
    check("midrun_rst_cnt", 32'(bus.issue_cnt), 0);
    check_adv("midrun_rst", 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_step_ctrl.md
# hazard_step_ctrl

Pipeline control unit for the five-stage MIPS core. It replaces the constant stall, flush and forward registers in `Pipe` with live hazard detection and forwarding selection. It also adds a run/halt/single-step run-control FSM so that a bench or a debug host can freeze and step the front end while the back end drains. The block sits beside the ID stage and drives the IF/ID latch enables, the ID/EX flush, and the four forwarding muxes.

## Interface
Parameters:
- ICNT_W, 16, width of the issued-instruction counter

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst_n  in  1  reset; synchronous, active-low
- RsD, RtD  in  5  source registers of the instruction in ID (InstrD[25:21], InstrD[20:16])
- RsE, RtE  in  5  source registers in EX
- WriteRegE, WriteRegM, WriteRegW  in  5  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write flags per stage
- MemtoRegE, MemtoRegM  in  1  load flags in EX and MEM
- BranchD  in  1  branch in ID
- PCSrcD  in  1  branch taken in ID
- run_req, halt_req, step_req  in  1  run-control requests, sampled every cycle
- StalIF, StalID  out  1  PC_REG and IF/ID latch enables; 1 = advance
- FlushD  out  1  IF/ID latch clear
- FlushE  out  1  ID/EX latch clear (inserts a bubble)
- ForwardAD, ForwardBD  out  1  ID compare-operand select; 1 = ALUOutM
- ForwardAE, ForwardBE  out  2  EX operand select; 00 = RD1E/RD2E, 01 = ResultW, 10 = ALUOutM; 11 is never driven
- halted  out  1  FSM is in HALTED
- issue_cnt  out  ICNT_W  count of ID→EX advances

## Operation
- **Register 0.** Register 0 never matches. Every compare below requires the compared source register to be nonzero.
- **ForwardAE.** 10 if RsE==WriteRegM & RegWriteM. Otherwise 01 if RsE==WriteRegW & RegWriteW. Otherwise 00. MEM has priority over WB.
- **ForwardBE.** Same rule as ForwardAE, using RtE.
- **ForwardAD / ForwardBD.** RsD (or RtD) == WriteRegM & RegWriteM.
- **lwstall.** MemtoRegE & (RtE==RsD | RtE==RtD), with RtE≠0.
- **branchstall.** BranchD & ((RegWriteE & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM∈{RsD,RtD})).
- **stall.** lwstall | branchstall.
- **FSM states:** HALTED, RUN, STEP. Request priority is halt_req > step_req > run_req.
  - HALTED: step_req → STEP; run_req → RUN.
  - RUN: halt_req → HALTED.
  - STEP: halt_req → HALTED (the step is aborted). Otherwise → HALTED on the first cycle with stall=0. Stay in STEP while stall=1.
  - Requests that do not apply to the current state are ignored. Requests are level-sampled, so holding step_req issues one step per pass through HALTED.
- **advance.** 1 when (state RUN or STEP) & ~stall.
- **Derived outputs:**
  - StalIF = StalID = advance.
  - FlushE = ~advance. While halted, EX/MEM/WB keep clocking bubbles and the pipeline drains.
  - FlushD = PCSrcD & advance. A frozen ID stage is never cleared.
- **issue_cnt.** Increments by 1 on every cycle with advance=1 and wraps modulo 2^ICNT_W.

## Timing
- Forward and stall terms are purely combinational from the inputs, with zero latency.
- State, issue_cnt and halted are registered.
- Run-control latency: a request sampled at edge N changes the state at edge N. The outputs reflect the new state in cycle N+1.
- Reset (rst_n=0 at an edge) → state HALTED, issue_cnt=0, halted=1, StalIF=StalID=0, FlushE=1, FlushD=0.
  - Forward outputs follow their inputs during reset; with all inputs at 0 they are all 0.
- Reset mid-step or mid-run → HALTED on that edge, with no counter increment on that edge.
- Single step: exactly one cycle with advance=1 per STEP visit. A stalled step therefore keeps StalID=0 until the hazard clears.
- halt_req together with step_req or run_req → halt wins.

## Test plan
- **Reset.** Hold rst_n=0 for 2 cycles, then release → StalIF=StalID=0, FlushE=1, halted=1, issue_cnt=0.
- **Free run.** Pulse run_req with no hazards → the next cycle shows StalID=1 and FlushE=0. After 10 cycles, issue_cnt=10. Pulse halt_req → the next cycle shows StalID=0 and halted=1, and the count holds at 10.
- **Load-use.** In RUN, set MemtoRegE=1, RegWriteE=1, RtE=5, RsD=5 → StalIF=StalID=0, FlushE=1, issue_cnt holds. Change RtE to 0 → no stall.
- **Forward priority.** Set RsE=3, WriteRegM=WriteRegW=3, RegWriteM=RegWriteW=1 → ForwardAE=10. Set RegWriteM=0 → 01. Set RsE=0 → 00. Repeat the same sequence on RtE/ForwardBE.
- **Stalled step.** In HALTED, pulse step_req while lwstall is held for 2 cycles → StalID=0 for those 2 cycles, then StalID=1 for exactly 1 cycle, issue_cnt +1, back to HALTED.
- **Branch and priority.**
  - BranchD=1, RegWriteE=1, WriteRegE=RsD=7 → stall=1.
  - PCSrcD=1 while halted → FlushD=0.
  - halt_req and run_req together in HALTED → stays HALTED.
